// File: rtl/reg_bank_arbiter_if.sv
// Register-bank access bundle: SPI write channel, two status writers, readout port and flags.
// The master side drives requests; the bank (slave) answers with ack/gnt, read data and status.
interface reg_bank_arbiter_if #(
    parameter int NREG = 16,
    parameter int DW   = 8
);
    logic                 spi_wr_valid;
    logic [7:0]           spi_wr_addr;
    logic [DW-1:0]        spi_wr_data;
    logic                 spi_wr_ack;
    logic [1:0]           st_req;
    logic [15:0]          st_addr;
    logic [2*DW-1:0]      st_data;
    logic [1:0]           st_gnt;
    logic [7:0]           rd_addr;
    logic [DW-1:0]        rd_data;
    logic [NREG*DW-1:0]   regs_flat;
    logic                 err_addr;
    logic                 err_ovf;
    logic                 busy;

    modport master (
        output spi_wr_valid, spi_wr_addr, spi_wr_data,
        output st_req, st_addr, st_data, rd_addr,
        input  spi_wr_ack, st_gnt, rd_data, regs_flat, err_addr, err_ovf, busy
    );

    modport slave (
        input  spi_wr_valid, spi_wr_addr, spi_wr_data,
        input  st_req, st_addr, st_data, rd_addr,
        output spi_wr_ack, st_gnt, rd_data, regs_flat, err_addr, err_ovf, busy
    );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Register bank shared by one SPI writer (strict priority, one-entry buffer) and two round-robin status writers.
// SPI write: ack 2 cycles after the pulse, visible 3 cycles after; overflowing SPI pulses are dropped and flagged, status writers wait on level req.
module reg_bank_arbiter #(
    parameter int NREG = 16,
    parameter int DW   = 8
) (
    input  logic             iclk,
    input  logic             rst,
    reg_bank_arbiter_if.slave bus
);
    localparam logic [8:0] NREG_LIM = 9'(NREG);

    typedef struct packed {
        logic [7:0]    addr;
        logic [DW-1:0] data;
    } wr_cmd_t;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SRC_SPI = 2'd0,
        SRC_ST0 = 2'd1,
        SRC_ST1 = 2'd2
    } src_t;

    state_t        state, state_nxt;
    src_t          src, src_nxt;
    wr_cmd_t       pend_cmd, wr_cmd;
    logic          spi_pend;
    logic          rr_ptr;
    logic          commit;
    logic          spi_ack;
    logic [1:0]    st_gnt;
    logic          wr_legal;
    logic          err_addr_q, err_ovf_q;
    logic [DW-1:0] rd_data_q, rd_next;
    logic [DW-1:0] bank [NREG];

    always_comb begin
        state_nxt = state;
        src_nxt   = src;
        commit    = 1'b0;
        spi_ack   = 1'b0;
        st_gnt    = 2'b00;
        wr_cmd    = pend_cmd;
        case (state)
            IDLE: begin
                if (spi_pend) begin
                    state_nxt = WRITE;
                    src_nxt   = SRC_SPI;
                // A fresh SPI pulse holds off status writers so SPI keeps strict priority.
                end else if (!bus.spi_wr_valid && (|bus.st_req)) begin
                    state_nxt = WRITE;
                    if (bus.st_req == 2'b11) begin
                        src_nxt = rr_ptr ? SRC_ST1 : SRC_ST0;
                    end else begin
                        src_nxt = bus.st_req[1] ? SRC_ST1 : SRC_ST0;
                    end
                end
            end
            WRITE: begin
                state_nxt = IDLE;
                case (src)
                    SRC_SPI: begin
                        commit  = 1'b1;
                        spi_ack = 1'b1;
                    end
                    SRC_ST0: begin
                        if (bus.st_req[0]) begin
                            commit      = 1'b1;
                            st_gnt      = 2'b01;
                            wr_cmd.addr = bus.st_addr[7:0];
                            wr_cmd.data = bus.st_data[DW-1:0];
                        end
                    end
                    SRC_ST1: begin
                        if (bus.st_req[1]) begin
                            commit      = 1'b1;
                            st_gnt      = 2'b10;
                            wr_cmd.addr = bus.st_addr[15:8];
                            wr_cmd.data = bus.st_data[2*DW-1:DW];
                        end
                    end
                    default: ;
                endcase
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign wr_legal = (wr_cmd.addr != 8'd0) && ({1'b0, wr_cmd.addr} < NREG_LIM);

    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NREG; i++) begin
            if (bus.rd_addr == 8'(i)) begin
                rd_next = bank[i];
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (rst) begin
            state      <= IDLE;
            src        <= SRC_SPI;
            spi_pend   <= 1'b0;
            pend_cmd   <= '0;
            rr_ptr     <= 1'b0;
            err_addr_q <= 1'b0;
            err_ovf_q  <= 1'b0;
            rd_data_q  <= '0;
            for (int i = 0; i < NREG; i++) begin
                bank[i] <= '0;
            end
        end else begin
            state     <= state_nxt;
            src       <= src_nxt;
            rd_data_q <= rd_next;

            // The buffer frees in its commit cycle, so a pulse landing then is kept.
            if (bus.spi_wr_valid) begin
                if (!spi_pend || spi_ack) begin
                    pend_cmd.addr <= bus.spi_wr_addr;
                    pend_cmd.data <= bus.spi_wr_data;
                    spi_pend      <= 1'b1;
                end else begin
                    err_ovf_q <= 1'b1;
                end
            end else if (spi_ack) begin
                spi_pend <= 1'b0;
            end

            if (|st_gnt) begin
                rr_ptr <= st_gnt[0];
            end

            if (commit && !wr_legal) begin
                err_addr_q <= 1'b1;
            end
            for (int i = 0; i < NREG; i++) begin
                if (commit && wr_legal && (wr_cmd.addr == 8'(i))) begin
                    bank[i] <= wr_cmd.data;
                end
            end
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign bus.regs_flat[g*DW +: DW] = bank[g];
    end

    assign bus.spi_wr_ack = spi_ack;
    assign bus.st_gnt     = st_gnt;
    assign bus.rd_data    = rd_data_q;
    assign bus.err_addr   = err_addr_q;
    assign bus.err_ovf    = err_ovf_q;
    assign bus.busy       = (state == WRITE) || spi_pend;
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: latency, round-robin, SPI priority, overflow, illegal addresses, reset abort.
module tb_reg_bank_arbiter;
    localparam int NREG = 16;
    localparam int DW   = 8;
    localparam int W    = NREG * DW;

    logic iclk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [DW-1:0] mdl [NREG];

    reg_bank_arbiter_if #(.NREG(NREG), .DW(DW)) bus ();

    reg_bank_arbiter #(.NREG(NREG), .DW(DW)) dut (
        .iclk (iclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, W'(obs), W'(exp));
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        chk(tag, W'(obs), W'(exp));
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        chk(tag, W'(obs), W'(exp));
    endtask

    function automatic logic [W-1:0] mdl_flat();
        logic [W-1:0] f;
        for (int i = 0; i < NREG; i++) f[i*DW +: DW] = mdl[i];
        return f;
    endfunction

    function automatic logic [7:0] reg_of(input int i);
        return bus.regs_flat[i*DW +: DW];
    endfunction

    task automatic cyc();
        @(negedge iclk);
    endtask

    task automatic spi(input logic v, input logic [7:0] a, input logic [7:0] d);
        bus.spi_wr_valid = v;
        bus.spi_wr_addr  = a;
        bus.spi_wr_data  = d;
    endtask

    initial begin
        rst = 1'b1;
        spi(1'b0, 8'h00, 8'h00);
        bus.st_req  = 2'b00;
        bus.st_addr = '0;
        bus.st_data = '0;
        bus.rd_addr = 8'h00;
        for (int i = 0; i < NREG; i++) mdl[i] = '0;
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_regs", bus.regs_flat, '0);
        chk8("rst_rd_data", bus.rd_data, 8'h00);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_ack", bus.spi_wr_ack, 1'b0);
        chk2("rst_gnt", bus.st_gnt, 2'b00);
        chk1("rst_err_addr", bus.err_addr, 1'b0);
        chk1("rst_err_ovf", bus.err_ovf, 1'b0);
        cyc();

        // SPI write latency and same-cycle read of the old value
        spi(1'b1, 8'h03, 8'hA5);
        cyc();
        chk1("lat_ack_n1", bus.spi_wr_ack, 1'b0);
        chk1("lat_busy_n1", bus.busy, 1'b1);
        spi(1'b0, 8'h00, 8'h00);
        cyc();
        chk1("lat_ack_n2", bus.spi_wr_ack, 1'b1);
        chk8("lat_reg3_n2", reg_of(3), 8'h00);
        bus.rd_addr = 8'h03;
        cyc();
        mdl[3] = 8'hA5;
        chk1("lat_ack_n3", bus.spi_wr_ack, 1'b0);
        chk8("lat_reg3_n3", reg_of(3), 8'hA5);
        chk8("rd_old_value", bus.rd_data, 8'h00);
        chk1("lat_busy_n3", bus.busy, 1'b0);
        cyc();
        chk8("rd_new_value", bus.rd_data, 8'hA5);

        // Round-robin between two held status requests
        bus.st_req  = 2'b11;
        bus.st_addr = {8'h05, 8'h04};
        bus.st_data = {8'h22, 8'h11};
        cyc();
        chk2("rr_gnt_first", bus.st_gnt, 2'b01);
        cyc();
        mdl[4] = 8'h11;
        chk2("rr_gnt_idle", bus.st_gnt, 2'b00);
        chk8("rr_reg4", reg_of(4), 8'h11);
        cyc();
        chk2("rr_gnt_second", bus.st_gnt, 2'b10);
        cyc();
        mdl[5] = 8'h22;
        bus.st_req = 2'b00;
        chk8("rr_reg5", reg_of(5), 8'h22);
        chk2("rr_gnt_done", bus.st_gnt, 2'b00);
        cyc();

        // SPI accepted in its predecessor's commit cycle; SPI beats a waiting status writer
        spi(1'b1, 8'h06, 8'h66);
        cyc();
        spi(1'b0, 8'h00, 8'h00);
        cyc();
        chk1("pri_ack_first", bus.spi_wr_ack, 1'b1);
        spi(1'b1, 8'h08, 8'h88);
        bus.st_req  = 2'b01;
        bus.st_addr = {8'h00, 8'h09};
        bus.st_data = {8'h00, 8'h99};
        cyc();
        mdl[6] = 8'h66;
        spi(1'b0, 8'h00, 8'h00);
        chk1("pri_ack_gap", bus.spi_wr_ack, 1'b0);
        chk1("pri_no_ovf", bus.err_ovf, 1'b0);
        chk1("pri_busy", bus.busy, 1'b1);
        chk2("pri_gnt_wait1", bus.st_gnt, 2'b00);
        cyc();
        chk1("pri_ack_second", bus.spi_wr_ack, 1'b1);
        chk2("pri_gnt_wait2", bus.st_gnt, 2'b00);
        cyc();
        mdl[8] = 8'h88;
        chk8("pri_reg8", reg_of(8), 8'h88);
        chk2("pri_gnt_wait3", bus.st_gnt, 2'b00);
        cyc();
        chk2("pri_gnt_st0", bus.st_gnt, 2'b01);
        cyc();
        mdl[9] = 8'h99;
        bus.st_req = 2'b00;
        chk("pri_regs", bus.regs_flat, mdl_flat());

        // Back-to-back SPI pulses during a status write: second one dropped
        bus.st_req  = 2'b10;
        bus.st_addr = {8'h0A, 8'h00};
        bus.st_data = {8'hAA, 8'h00};
        cyc();
        chk2("ovf_gnt_st1", bus.st_gnt, 2'b10);
        spi(1'b1, 8'h0B, 8'hBB);
        cyc();
        mdl[10] = 8'hAA;
        chk8("ovf_reg10", reg_of(10), 8'hAA);
        bus.st_req = 2'b00;
        spi(1'b1, 8'h0C, 8'hCC);
        cyc();
        spi(1'b0, 8'h00, 8'h00);
        chk1("ovf_ack", bus.spi_wr_ack, 1'b1);
        chk1("ovf_flag", bus.err_ovf, 1'b1);
        cyc();
        mdl[11] = 8'hBB;
        chk8("ovf_reg11", reg_of(11), 8'hBB);
        chk8("ovf_reg12_dropped", reg_of(12), 8'h00);
        chk1("ovf_busy_after", bus.busy, 1'b0);

        // Illegal addresses still handshake but leave the bank alone
        spi(1'b1, 8'h00, 8'h5A);
        cyc();
        spi(1'b0, 8'h00, 8'h00);
        cyc();
        chk1("ill_ack_a0", bus.spi_wr_ack, 1'b1);
        chk1("ill_err_before", bus.err_addr, 1'b0);
        spi(1'b1, 8'h10, 8'h77);
        cyc();
        spi(1'b0, 8'h00, 8'h00);
        chk1("ill_err_a0", bus.err_addr, 1'b1);
        chk8("ill_reg0", reg_of(0), 8'h00);
        cyc();
        chk1("ill_ack_a16", bus.spi_wr_ack, 1'b1);
        cyc();
        chk("ill_regs_unchanged", bus.regs_flat, mdl_flat());
        chk8("ill_rd_before", bus.rd_data, 8'hA5);
        chk1("ill_err_ovf_sticky", bus.err_ovf, 1'b1);
        bus.rd_addr = 8'h10;
        cyc();
        chk8("ill_rd_oob", bus.rd_data, 8'h00);
        chk1("ill_busy", bus.busy, 1'b0);

        // Reset in the WRITE cycle aborts the commit and discards a new pending write
        spi(1'b1, 8'h07, 8'hFF);
        cyc();
        spi(1'b0, 8'h00, 8'h00);
        cyc();
        chk1("rstw_ack", bus.spi_wr_ack, 1'b1);
        rst = 1'b1;
        spi(1'b1, 8'h02, 8'h22);
        cyc();
        rst = 1'b0;
        spi(1'b0, 8'h00, 8'h00);
        for (int i = 0; i < NREG; i++) mdl[i] = '0;
        chk8("rstw_reg7", reg_of(7), 8'h00);
        chk("rstw_regs", bus.regs_flat, mdl_flat());
        chk1("rstw_busy", bus.busy, 1'b0);
        chk1("rstw_ack_cleared", bus.spi_wr_ack, 1'b0);
        chk1("rstw_err_addr", bus.err_addr, 1'b0);
        chk1("rstw_err_ovf", bus.err_ovf, 1'b0);
        cyc();
        chk1("rstw_no_ack1", bus.spi_wr_ack, 1'b0);
        chk1("rstw_busy1", bus.busy, 1'b0);
        cyc();
        chk1("rstw_no_ack2", bus.spi_wr_ack, 1'b0);
        chk8("rstw_reg2", reg_of(2), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
